cpu_axi_bridge: RTL and testbench

//  Converts the core's inst and data request ports into one AXI3 master.

---
 rtl/cpu_axi_bridge_pkg.sv | 17 +
 rtl/cpu_axi_bridge_if.sv | 74 +++++++
 rtl/cpu_axi_bridge.sv | 133 +++++++++++++
 tb/tb_cpu_axi_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the core-to-AXI3 bridge.
package cpu_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WR,
        B,
        RESP
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         ID_INST        = 0;
    localparam int         ID_DATA        = 1;

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master bus of the bridge; single-beat transfers only.
interface cpu_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/cpu_axi_bridge.sv
// Merges the core's inst/data request ports into one AXI3 master with a
// single outstanding transaction; the data port wins arbitration.
module cpu_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [3:0]        inst_wstrb,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    cpu_axi_bridge_if.master  axi
);

    state_t            state, state_nx;
    logic              owner_q;          // 1 = data port owns the transaction
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done, w_done;
    logic [DATA_W-1:0] rdata_q;
    logic              grant;

    always_comb begin
        data_addr_ok = (state == IDLE) & data_req;
        inst_addr_ok = (state == IDLE) & inst_req & ~data_req;
        grant        = data_addr_ok | inst_addr_ok;
        state_nx     = state;
        case (state)
            IDLE:    if (grant) state_nx = (data_req ? data_wr : inst_wr) ? WR : AR;
            AR:      if (axi.arready) state_nx = R;
            R:       if (axi.rvalid) state_nx = RESP;
            WR:      if (aw_done & w_done) state_nx = B;
            B:       if (axi.bvalid) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= data_req;
                size_q  <= data_req ? data_size  : inst_size;
                addr_q  <= data_req ? data_addr  : inst_addr;
                wstrb_q <= data_req ? data_wstrb : inst_wstrb;
                wdata_q <= data_req ? data_wdata : inst_wdata;
            end
            // Done flags are cleared in IDLE so both channels start fresh in WR.
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR) begin
                if (axi.awvalid & axi.awready) aw_done <= 1'b1;
                if (axi.wvalid & axi.wready)   w_done  <= 1'b1;
            end
            if ((state == R) & axi.rvalid) rdata_q <= axi.rdata;
        end
    end

    assign axi.arid    = owner_q ? ID_W'(ID_DATA) : ID_W'(ID_INST);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = '0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = (state == AR);
    assign axi.rready  = (state == R);

    assign axi.awid    = ID_W'(ID_DATA);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = '0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.awvalid = (state == WR) & ~aw_done;

    assign axi.wid     = ID_W'(ID_DATA);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state == WR) & ~w_done;
    assign axi.bready  = (state == B);

    assign inst_data_ok = (state == RESP) & ~owner_q;
    assign data_data_ok = (state == RESP) &  owner_q;
    assign inst_rdata   = rdata_q;
    assign data_rdata   = rdata_q;

    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge with a delay-programmable AXI slave model.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;

    cpu_axi_bridge_if axi ();

    cpu_axi_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi)
    );

    initial forever #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'h1c00_0000) ? 32'h02c0_0000 : {a[15:0], ~a[15:0]};
    endfunction

    // Slave model: each ready/valid rises after its programmed number of wait cycles.
    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rid = '0; axi.rresp = '0;
        axi.rlast = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0;
        axi.bresp = '0;
        forever begin
            @(negedge clk);
            if (axi.arvalid) begin
                if (ar_wait < ar_delay) begin axi.arready = 0; ar_wait++; end
                else axi.arready = 1;
            end else begin axi.arready = 0; ar_wait = 0; end
            if (axi.rready) begin
                if (r_wait < r_delay) begin axi.rvalid = 0; r_wait++; end
                else begin axi.rvalid = 1; axi.rlast = 1; axi.rdata = model(axi.araddr); end
            end else begin axi.rvalid = 0; axi.rlast = 0; r_wait = 0; end
            if (axi.awvalid) begin
                if (aw_wait < aw_delay) begin axi.awready = 0; aw_wait++; end
                else axi.awready = 1;
            end else begin axi.awready = 0; aw_wait = 0; end
            if (axi.wvalid) begin
                if (w_wait < w_delay) begin axi.wready = 0; w_wait++; end
                else axi.wready = 1;
            end else begin axi.wready = 0; w_wait = 0; end
            axi.bvalid = axi.bready;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
    endfunction

    task automatic wait_ok(input bit dside, input string tag, input logic [31:0] exp,
                           input bit chk_rd);
        int n = 0;
        while (((dside ? data_data_ok : inst_data_ok) !== 1'b1) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_data_ok"}, dside ? data_data_ok : inst_data_ok, 1);
        if (chk_rd) chk({tag, "_rdata"}, dside ? data_rdata : inst_rdata, exp);
        tick();
        chk({tag, "_pulse_end"}, dside ? data_data_ok : inst_data_ok, 0);
    endtask

    logic [31:0] a6 [4] = '{32'h100, 32'h104, 32'h108, 32'h10c};
    logic [31:0] e6 [4] = '{32'h0100_FEFF, 32'h0104_FEFB, 32'h0108_FEF7, 32'h010C_FEF3};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gi, oi, last, aw_hs_cyc;
        bit aw_hs;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        resetn = 1;
        #2 resetn = 0;
        #1;
        chk("rst_outs", outs(), 0);
        chk("rst_rdata", data_rdata, 0);
        tick(); tick();
        resetn = 1;

        // 1: inst read, rvalid two cycles into R
        r_delay = 2;
        tick(); inst_req = 1; inst_size = 2; inst_addr = 32'h1c00_0000; #1;
        chk("t1_addr_ok", inst_addr_ok, 1);
        tick(); inst_req = 0;
        chk("t1_arvalid", axi.arvalid, 1);
        chk("t1_arid", axi.arid, 0);
        chk("t1_arsize", axi.arsize, 2);
        chk("t1_araddr", axi.araddr, 32'h1c00_0000);
        chk("t1_arburst", axi.arburst, 2'b01);
        wait_ok(0, "t1", 32'h02c0_0000, 1);
        r_delay = 0;

        // 2: simultaneous requests, data first
        tick(); inst_req = 1; inst_addr = 32'h1c00_0000; inst_size = 2;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h200; #1;
        chk("t2_data_aok", data_addr_ok, 1);
        chk("t2_inst_aok_lose", inst_addr_ok, 0);
        tick(); data_req = 0; #1;
        chk("t2_inst_aok_busy", inst_addr_ok, 0);
        chk("t2_arid_data", axi.arid, 1);
        chk("t2_araddr", axi.araddr, 32'h200);
        wait_ok(1, "t2d", 32'h0200_FDFF, 1);
        chk("t2_inst_aok_idle", inst_addr_ok, 1);
        tick(); inst_req = 0;
        chk("t2_arid_inst", axi.arid, 0);
        wait_ok(0, "t2i", 32'h02c0_0000, 1);

        // 3: byte write, W accepted at once, AW three cycles late
        aw_delay = 3;
        tick(); data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003;
        data_wstrb = 4'b1000; data_wdata = 32'h1200_0000; #1;
        chk("t3_addr_ok", data_addr_ok, 1);
        tick(); data_req = 0; data_wr = 0;
        chk("t3_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        chk("t3_awaddr", axi.awaddr, 32'h8000_0003);
        chk("t3_awsize", axi.awsize, 0);
        chk("t3_wstrb", axi.wstrb, 4'b1000);
        chk("t3_wdata", axi.wdata, 32'h1200_0000);
        chk("t3_ids_wlast", {axi.awid, axi.wid, axi.wlast}, 9'b0001_0001_1);
        tick();
        chk("t3_w_dropped", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        n = 0; aw_hs = 0; aw_hs_cyc = 0;
        while (axi.bready !== 1'b1 && n < 20) begin
            if (axi.awvalid && axi.awready) begin aw_hs = 1; aw_hs_cyc = cyc; end
            tick();
            n++;
        end
        chk("t3_bready", axi.bready, 1);
        chk("t3_b_after_aw", aw_hs && (cyc > aw_hs_cyc), 1);
        chk("t3_no_ok_in_b", data_data_ok, 0);
        tick();
        chk("t3_data_ok", data_data_ok, 1);
        tick();
        chk("t3_pulse_end", data_data_ok, 0);
        aw_delay = 0;

        // 4: arready stalled five cycles, inst held pending
        ar_delay = 5;
        tick(); data_req = 1; data_size = 1; data_addr = 32'h0000_1234; #1;
        chk("t4_addr_ok", data_addr_ok, 1);
        tick(); data_req = 0; inst_req = 1; inst_addr = 32'h40; inst_size = 2; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_arvalid", axi.arvalid, 1);
            chk("t4_araddr", axi.araddr, 32'h0000_1234);
            chk("t4_arsize", axi.arsize, 1);
            chk("t4_no_aok", {inst_addr_ok, data_addr_ok}, 0);
            if (i < 4) tick();
        end
        ar_delay = 0;
        wait_ok(1, "t4d", 32'h1234_EDCB, 1);
        chk("t4_inst_aok", inst_addr_ok, 1);
        tick(); inst_req = 0;
        wait_ok(0, "t4i", 32'h0040_FFBF, 1);

        // 5: reset while waiting in R
        r_delay = 10;
        tick(); inst_req = 1; inst_addr = 32'h1c00_0000; #1;
        chk("t5_addr_ok", inst_addr_ok, 1);
        tick(); inst_req = 0;
        n = 0;
        while (axi.rready !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5_in_r", {axi.rready, axi.rvalid}, 2'b10);
        resetn = 0; #1;
        chk("t5_rst_outs", outs(), 0);
        chk("t5_rst_rdata", inst_rdata, 0);
        r_delay = 0;
        tick(); resetn = 1;
        tick(); data_req = 1; data_size = 2; data_addr = 32'h300; #1;
        chk("t5_regrant", data_addr_ok, 1);
        tick(); data_req = 0;
        chk("t5_arvalid", axi.arvalid, 1);
        wait_ok(1, "t5", 32'h0300_FCFF, 1);

        // 6: four back-to-back zero-latency data reads
        gi = 0; oi = 0; last = 0;
        for (int k = 0; k < 30 && oi < 4; k++) begin
            tick();
            data_req = (gi < 4); data_wr = 0; data_size = 2; data_addr = a6[gi < 4 ? gi : 0];
            #1;
            if (data_data_ok) begin
                chk("t6_rdata", data_rdata, e6[oi]);
                oi++;
            end
            if (data_addr_ok) begin
                if (gi > 0) chk("t6_gap", cyc - last, 4);
                last = cyc;
                gi++;
            end
        end
        data_req = 0;
        chk("t6_grants", gi, 4);
        chk("t6_resps", oi, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
